// File: rtl/shift_sequencer.sv
// Multi-cycle logarithmic shifter: one shamt bit applied per cycle, LSB first,
// with valid/ready handshakes on both the operation and result sides.
module shift_sequencer #(
    parameter  int N = 32,
    localparam int L = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_op,
    input  logic [N-1:0] in_data,
    input  logic [L-1:0] in_shamt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0]   OP_SLL     = 2'b00;
    localparam logic [1:0]   OP_SRL     = 2'b01;
    localparam logic [1:0]   OP_SRA     = 2'b11;
    localparam logic [L-1:0] LAST_STAGE = L[L-1:0] - 1'b1;

    state_t         state_r;
    logic [N-1:0]   data_r;
    logic [1:0]     op_r;
    logic [L-1:0]   shamt_r;
    logic           fill_r;
    logic [L-1:0]   cnt_r;
    logic           in_ready_r;
    logic           out_valid_r;
    logic [N-1:0]   stage_data_s;

    // One stage: shift by 2^k in the latched direction; the reserved op holds.
    function automatic logic [N-1:0] shift_stage(input logic [N-1:0] d,
                                                 input logic [1:0]   op,
                                                 input logic         fill,
                                                 input logic [L-1:0] k);
        logic [2*N-1:0] ext;
        logic [N-1:0]   res;
        int unsigned    amt;
        amt = 32'd1 << k;
        ext = {{N{fill}}, d} >> amt;
        case (op)
            OP_SLL:  res = d << amt;
            OP_SRL:  res = d >> amt;
            OP_SRA:  res = ext[N-1:0];
            default: res = d;
        endcase
        return res;
    endfunction

    // Next working-register value for the current stage.
    always_comb begin
        stage_data_s = data_r;
        if (shamt_r[cnt_r]) begin
            stage_data_s = shift_stage(data_r, op_r, fill_r, cnt_r);
        end else begin
            stage_data_s = data_r;
        end
    end

    // Control FSM, working register and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            data_r      <= '0;
            op_r        <= 2'b00;
            shamt_r     <= '0;
            fill_r      <= 1'b0;
            cnt_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_r     <= in_data;
                        op_r       <= in_op;
                        shamt_r    <= in_shamt;
                        fill_r     <= in_data[N-1];
                        cnt_r      <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    data_r <= stage_data_s;
                    cnt_r  <= cnt_r + 1'b1;
                    if (cnt_r == LAST_STAGE) begin
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = data_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: stimulus pushes expected results,
// a monitor compares them whenever the DUT presents a result.
module tb_shift_sequencer;

    localparam int N = 32;
    localparam int L = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [N-1:0]  in_data;
    logic [L-1:0]  in_shamt;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;

    int            tests = 0;
    int            fails = 0;
    int            cyc   = 0;
    logic [N-1:0]  exp_q[$];

    shift_sequencer #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_data(in_data), .in_shamt(in_shamt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare presented result with scoreboard head; pop on consume.
    always @(negedge clk) begin
        #1;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got 0x%08h expected none", out_data);
            end else begin
                check("result", out_data, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Wait at negedges until in_ready, then present the op for one accept edge.
    task automatic send(input logic [1:0] op, input logic [N-1:0] d, input logic [L-1:0] sh,
                        input logic [N-1:0] exp, output int acc);
        int t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_shamt = sh;
        exp_q.push_back(exp);
        @(negedge clk);
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    // Count negedges from the accept until out_valid is seen.
    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run(input string name, input logic [1:0] op, input logic [N-1:0] d,
                       input logic [L-1:0] sh, input logic [N-1:0] exp);
        int acc, n;
        send(op, d, sh, exp, acc);
        wait_out(n);
        check({name, "_latency"}, n, L);
        @(negedge clk);
        check({name, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
        check({name, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int acc, acc2, n, t;
        rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_data = '0; in_shamt = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        run("sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000);
        run("sra4", 2'b11, 32'h8000_00F0, 5'd4, 32'hF800_000F);
        run("srl4", 2'b01, 32'h8000_00F0, 5'd4, 32'h0800_000F);
        run("srl0", 2'b01, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
        run("rsv7", 2'b10, 32'hDEAD_BEEF, 5'd7, 32'hDEAD_BEEF);

        // Backpressure with an ignored in_valid pulse during DONE.
        out_ready = 1'b0;
        send(2'b00, 32'h0000_00FF, 5'd8, 32'h0000_FF00, acc);
        wait_out(n);
        check("bp_latency", n, L);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 3);
            in_data  = 32'h1234_5678;
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_hold_data", out_data, 32'h0000_FF00);
        check("bp_queue_empty", exp_q.size(), 32'd0);

        // Reset on the third stage edge discards the operation.
        send(2'b11, 32'hFFFF_0000, 5'd16, 32'hFFFF_FFFF, acc);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_out_data", out_data, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        run("post_rst_sll1", 2'b00, 32'h0000_0001, 5'd1, 32'h0000_0002);

        // Back-to-back with in_valid held high.
        in_valid = 1'b1; in_op = 2'b00; in_data = 32'h3; in_shamt = 5'd2;
        exp_q.push_back(32'h0000_000C);
        @(negedge clk);
        acc = cyc;
        in_op = 2'b01; in_data = 32'h80; in_shamt = 5'd7;
        exp_q.push_back(32'h0000_0001);
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        acc2 = cyc;
        in_valid = 1'b0;
        check("b2b_interval", acc2 - acc, L + 2);
        wait_out(n);
        check("b2b_latency", n, L);
        @(negedge clk);
        @(negedge clk);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shift unit for the multicycle core's execute stage.
- Sits beside the combinational shifters; the controller uses it when a single-cycle barrel mux is too costly.
- Accepts one shift operation over a valid/ready handshake and performs a logarithmic shift: one shamt bit per cycle, LSB first.
- Presents the result to the writeback register over a second valid/ready handshake.

Parameters:
- N, 32, datapath width in bits; must be a power of two ≥ 2.
- L, $clog2(N), number of shift stages; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has an operation on in_*.
- in_ready  output  1  block can accept an operation this cycle.
- in_op  input  2  00 SLL, 01 SRL, 11 SRA, 10 reserved.
- in_data  input  N  operand to shift.
- in_shamt  input  L  shift amount, 0..N-1.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  downstream consumes result this cycle.
- out_data  output  N  shift result.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, in_ready=1, out_valid=0, out_data=0, stage counter=0.
  - Reset overrides every other input, including mid-SHIFT or DONE; the in-flight operation is discarded with no result.
- States:
  - IDLE: in_ready=1, out_valid=0. On an edge with in_valid=1, latch in_data into the working register (drives out_data), latch in_op and in_shamt, latch fill bit, clear counter, go to SHIFT. Otherwise stay.
  - SHIFT: in_ready=0, out_valid=0.
    - Each edge applies stage k = counter. If shamt[k]=1, the working register shifts by 2^k in the op direction; if 0, it holds.
    - Counter increments. On the edge where k=L-1, go to DONE.
  - DONE: in_ready=0, out_valid=1, out_data stable. On an edge with out_ready=1, go to IDLE. Otherwise hold indefinitely.
- Fill rules:
  - SLL: zero fill at LSBs.
  - SRL: zero fill at MSBs.
  - SRA: fill with in_data[N-1] as latched at acceptance.
  - Reserved op 10: working register never changes (result = in_data); same latency.
- Latency:
  - Accept at edge E0; stages at E1..EL; out_valid=1 from EL until the consuming edge.
  - in_ready returns high the cycle after consumption.
  - Minimum issue interval is L+2 cycles. No overlap and no bypass: in_valid during SHIFT or DONE is ignored and must be held by upstream.
- Boundaries:
  - shamt=0 still takes L stage cycles; result = in_data.
  - shamt=N-1 for SLL yields {in_data[0], (N-1) zeros}.
  - Inputs are sampled only at the accept edge; changes afterwards have no effect.
- Output stability:
  - out_data during SHIFT shows intermediate values and is not meaningful.
  - out_data during DONE is constant.
  - After returning to IDLE, out_data keeps the last result until the next accept.

Test Plan:
- Reset, then SLL in_data=0x0000_0001, shamt=31, out_ready=1 → out_valid rises exactly 5 edges after accept, out_data=0x8000_0000; in_ready=1 the cycle after consumption.
- SRA in_data=0x8000_00F0, shamt=4 → 0xF800_000F. SRL with the same operands → 0x0800_000F.
- SRL in_data=0xDEAD_BEEF, shamt=0 → 0xDEAD_BEEF after 5 stage cycles. Reserved op 10 with shamt=7 → 0xDEAD_BEEF.
- Backpressure: SLL 0x0000_00FF shamt=8, out_ready=0 for 10 cycles after out_valid → out_valid stays 1, out_data stays 0x0000_FF00, in_ready stays 0. A new in_valid pulse during this window is not accepted. Raise out_ready → one consume, then IDLE.
- Reset mid-operation: accept SRA 0xFFFF_0000 shamt=16, assert rst on the 3rd stage edge → next cycle out_valid=0, out_data=0, in_ready=1. A following SLL 0x1 shamt=1 returns 0x0000_0002.
- Back-to-back: two operations with in_valid held high and out_ready=1 → second accept occurs exactly L+2 cycles after the first. Both results correct (SLL 0x3 by 2 → 0xC; SRL 0x80 by 7 → 0x1).
